fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 124 ++++++++++++
 tb/tb_fb_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Two-requester round-robin framebuffer write arbiter with a registered write port.
// The clear engine is built only when FB_WRITE_ARBITER_CLEAR_EN is defined.
module fb_write_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int CLEAR_WORDS = 1200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_value,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [DATA_WIDTH-1:0] fb_wdata
);

    localparam logic [0:0] IDLE = 1'b0;

    logic [0:0]            state;
    logic                  prio1;
    logic                  clear_go;
    logic                  clear_wr;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic [DATA_WIDTH-1:0] clear_fill;
    logic                  open;
    logic                  grant0;
    logic                  grant1;

`ifdef FB_WRITE_ARBITER_CLEAR_EN
    localparam logic [0:0] CLEAR = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CLEAR_WORDS - 1);

    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] fill;
    logic                  done;

    // Word 0 is issued on the start edge; cnt tracks the last issued address.
    assign clear_go   = clear_start && (state == IDLE);
    assign clear_wr   = clear_go || ((state == CLEAR) && (cnt != LAST));
    assign clear_addr = clear_go ? '0 : cnt + ADDR_WIDTH'(1);
    assign clear_fill = clear_go ? clear_value : fill;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            fill  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear_go) begin
                state <= CLEAR;
                cnt   <= '0;
                fill  <= clear_value;
            end else if (state == CLEAR) begin
                if (cnt == LAST) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else begin
                    cnt <= cnt + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign clear_busy = (state == CLEAR);
    assign clear_done = done;
`else
    localparam int unused_words = CLEAR_WORDS;

    logic unused_clear;

    assign unused_clear = ^{clear_start, clear_value};
    assign state        = IDLE;
    assign clear_go     = 1'b0;
    assign clear_wr     = 1'b0;
    assign clear_addr   = '0;
    assign clear_fill   = '0;
    assign clear_busy   = 1'b0;
    assign clear_done   = 1'b0;
`endif

    // prio1 set means requester 1 wins the next tie.
    assign open   = !reset && (state == IDLE) && !clear_go;
    assign grant0 = open && req0_valid && (!req1_valid || !prio1);
    assign grant1 = open && req1_valid && (!req0_valid || prio1);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= '0;
            prio1    <= 1'b0;
        end else begin
            fb_we <= grant0 || grant1 || clear_wr;
            if (grant0) begin
                fb_addr  <= req0_addr;
                fb_wdata <= req0_data;
                prio1    <= 1'b1;
            end else if (grant1) begin
                fb_addr  <= req1_addr;
                fb_wdata <= req1_data;
                prio1    <= 1'b0;
            end else if (clear_wr) begin
                fb_addr  <= clear_addr;
                fb_wdata <= clear_fill;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter; clear scenarios run only when
// FB_WRITE_ARBITER_CLEAR_EN is defined, otherwise the disabled-clear behaviour is checked.
module tb_fb_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        clear_start;
    logic [31:0] clear_value;
    logic        clear_busy, clear_done;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [31:0] fb_wdata;

    int n_cmp = 0;
    int n_err = 0;

    fb_write_arbiter #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .CLEAR_WORDS(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .clear_start(clear_start),
        .clear_value(clear_value),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        step();
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready0 got %b want 0", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready1 got %b want 0", req1_ready); end
        n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL rst_we got %b want 0", fb_we); end
        n_cmp++; if (fb_addr !== 16'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", fb_addr); end
        n_cmp++; if (fb_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata got %h want 0", fb_wdata); end
        n_cmp++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", clear_busy); end
        n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", clear_done); end
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_single();
        req0_valid = 1'b1;
        req0_addr  = 16'h0010;
        req0_data  = 32'hAABBCCDD;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready0 got %b want 1", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL single_ready1 got %b want 0", req1_ready); end
        step();
        req0_valid = 1'b0;
        n_cmp++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL single_we got %b want 1", fb_we); end
        n_cmp++; if (fb_addr !== 16'h0010) begin n_err++; $display("FAIL single_addr got %h want 0010", fb_addr); end
        n_cmp++; if (fb_wdata !== 32'hAABBCCDD) begin n_err++; $display("FAIL single_data got %h want aabbccdd", fb_wdata); end
        step();
        n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL idle_we got %b want 0", fb_we); end
        n_cmp++; if (fb_addr !== 16'h0010) begin n_err++; $display("FAIL idle_addr_hold got %h want 0010", fb_addr); end
    endtask

    task automatic test_contention();
        logic [15:0] ea;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_addr  = 16'(32'h0100 + i);
            req1_addr  = 16'(32'h0200 + i);
            req0_data  = 32'hC0DE0000 + i;
            req1_data  = 32'hBEEF0000 + i;
            ea = (i % 2 == 0) ? req0_addr : req1_addr;
            #1;
            n_cmp++; if (req0_ready !== (i % 2 == 0)) begin n_err++; $display("FAIL rr_ready0[%0d] got %b want %b", i, req0_ready, (i % 2 == 0)); end
            n_cmp++; if (req1_ready !== (i % 2 == 1)) begin n_err++; $display("FAIL rr_ready1[%0d] got %b want %b", i, req1_ready, (i % 2 == 1)); end
            step();
            n_cmp++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL rr_we[%0d] got %b want 1", i, fb_we); end
            n_cmp++; if (fb_addr !== ea) begin n_err++; $display("FAIL rr_addr[%0d] got %h want %h", i, fb_addr, ea); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  v0 = 4'b0101;
        logic [3:0]  v1 = 4'b1110;
        logic [3:0]  g1 = 4'b1010;
        logic [15:0] ea;
        for (int i = 0; i < 4; i++) begin
            req0_valid = v0[i];
            req1_valid = v1[i];
            req0_addr  = 16'(32'h0300 + i);
            req1_addr  = 16'(32'h0400 + i);
            req0_data  = {16'hD0D0, req0_addr};
            req1_data  = {16'hD1D1, req1_addr};
            ea = g1[i] ? req1_addr : req0_addr;
            #1;
            n_cmp++; if (req1_ready !== g1[i]) begin n_err++; $display("FAIL b2b_ready1[%0d] got %b want %b", i, req1_ready, g1[i]); end
            n_cmp++; if (req0_ready !== !g1[i]) begin n_err++; $display("FAIL b2b_ready0[%0d] got %b want %b", i, req0_ready, !g1[i]); end
            step();
            n_cmp++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL b2b_we[%0d] got %b want 1", i, fb_we); end
            n_cmp++; if (fb_addr !== ea) begin n_err++; $display("FAIL b2b_addr[%0d] got %h want %h", i, fb_addr, ea); end
            n_cmp++; if (fb_wdata[15:0] !== ea) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", i, fb_wdata[15:0], ea); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL b2b_tail_we got %b want 0", fb_we); end
    endtask

`ifdef FB_WRITE_ARBITER_CLEAR_EN
    task automatic test_clear();
        req1_valid  = 1'b1;
        req1_addr   = 16'h0ABC;
        req1_data   = 32'h11112222;
        clear_start = 1'b1;
        clear_value = 32'h00000000;
        #1;
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL clr_start_ready1 got %b want 0", req1_ready); end
        step();
        clear_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL clr_we[%0d] got %b want 1", k, fb_we); end
            n_cmp++; if (fb_addr !== 16'(k)) begin n_err++; $display("FAIL clr_addr[%0d] got %h want %h", k, fb_addr, 16'(k)); end
            n_cmp++; if (fb_wdata !== 32'h0) begin n_err++; $display("FAIL clr_data[%0d] got %h want 0", k, fb_wdata); end
            n_cmp++; if (clear_busy !== 1'b1) begin n_err++; $display("FAIL clr_busy[%0d] got %b want 1", k, clear_busy); end
            n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL clr_done_early[%0d] got %b want 0", k, clear_done); end
            n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready1[%0d] got %b want 0", k, req1_ready); end
            step();
        end
        n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL clr_end_we got %b want 0", fb_we); end
        n_cmp++; if (clear_done !== 1'b1) begin n_err++; $display("FAIL clr_done got %b want 1", clear_done); end
        n_cmp++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL clr_end_busy got %b want 0", clear_busy); end
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL clr_done_grant got %b want 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL clr_done_pulse got %b want 0", clear_done); end
        n_cmp++; if (fb_addr !== 16'h0ABC) begin n_err++; $display("FAIL clr_post_addr got %h want 0abc", fb_addr); end
        step();
    endtask

    task automatic test_clear_collide();
        int writes = 0;
        int dones  = 0;
        req0_valid  = 1'b1;
        req0_addr   = 16'h0055;
        req0_data   = 32'h12345678;
        clear_start = 1'b1;
        clear_value = 32'h5A5A5A5A;
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL coll_ready0 got %b want 0", req0_ready); end
        step();
        clear_start = 1'b0;
        req0_valid  = 1'b0;
        for (int k = 0; k < 14; k++) begin
            clear_start = (k == 3);
            if (fb_we) begin
                writes++;
                n_cmp++; if (fb_wdata !== 32'h5A5A5A5A) begin n_err++; $display("FAIL coll_data[%0d] got %h want 5a5a5a5a", k, fb_wdata); end
            end
            if (clear_done) dones++;
            step();
        end
        clear_start = 1'b0;
        n_cmp++; if (writes !== 8) begin n_err++; $display("FAIL coll_writes got %0d want 8", writes); end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL coll_dones got %0d want 1", dones); end
        n_cmp++; if (fb_addr !== 16'h0007) begin n_err++; $display("FAIL coll_last_addr got %h want 0007", fb_addr); end
    endtask

    task automatic test_reset_mid_clear();
        clear_start = 1'b1;
        clear_value = 32'hFFFF0000;
        step();
        clear_start = 1'b0;
        step();
        step();
        step();
        n_cmp++; if (fb_addr !== 16'h0003) begin n_err++; $display("FAIL mid_addr got %h want 0003", fb_addr); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL mid_we got %b want 0", fb_we); end
        n_cmp++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", clear_busy); end
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL mid_stray_we[%0d] got %b want 0", k, fb_we); end
            n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL mid_done[%0d] got %b want 0", k, clear_done); end
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL mid_rr_ready0 got %b want 1", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL mid_rr_ready1 got %b want 0", req1_ready); end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_cmp++; if (fb_addr !== req0_addr) begin n_err++; $display("FAIL mid_rr_addr got %h want %h", fb_addr, req0_addr); end
    endtask
`else
    task automatic test_no_clear();
        req0_valid  = 1'b1;
        req0_addr   = 16'h0777;
        req0_data   = 32'hCAFEF00D;
        clear_start = 1'b1;
        clear_value = 32'hFFFFFFFF;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL nc_ready0 got %b want 1", req0_ready); end
        step();
        clear_start = 1'b0;
        req0_valid  = 1'b0;
        n_cmp++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL nc_we got %b want 1", fb_we); end
        n_cmp++; if (fb_addr !== 16'h0777) begin n_err++; $display("FAIL nc_addr got %h want 0777", fb_addr); end
        n_cmp++; if (fb_wdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL nc_data got %h want cafef00d", fb_wdata); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL nc_busy[%0d] got %b want 0", k, clear_busy); end
            n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL nc_done[%0d] got %b want 0", k, clear_done); end
            step();
            n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL nc_idle_we[%0d] got %b want 0", k, fb_we); end
        end
        req1_valid = 1'b1;
        req1_addr  = 16'h0888;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL nc_ready1 got %b want 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        n_cmp++; if (fb_addr !== 16'h0888) begin n_err++; $display("FAIL nc_addr1 got %h want 0888", fb_addr); end
    endtask
`endif

    initial begin
        reset       = 1'b1;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req0_addr   = '0;
        req1_addr   = '0;
        req0_data   = '0;
        req1_data   = '0;
        clear_start = 1'b0;
        clear_value = '0;
        step();
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
`ifdef FB_WRITE_ARBITER_CLEAR_EN
        test_clear();
        test_clear_collide();
        test_reset_mid_clear();
`else
        test_no_clear();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
